// File: rtl/countdown_timer_if.sv
// Control, preset and display signals of the countdown timer stage.
interface countdown_timer_if;
  logic        load;
  logic        start;
  logic        pause;
  logic [4:0]  preset_h;
  logic [5:0]  preset_m;
  logic [5:0]  preset_s;
  logic [31:0] time_data;
  logic [1:0]  state;
  logic        running;
  logic        expired;
  logic        expire_pulse;

  modport master (
    output load, start, pause, preset_h, preset_m, preset_s,
    input  time_data, state, running, expired, expire_pulse
  );

  modport slave (
    input  load, start, pause, preset_h, preset_m, preset_s,
    output time_data, state, running, expired, expire_pulse
  );
endinterface

// File: rtl/countdown_timer_core.sv
// H:M:S countdown on the 1 Hz tick with packed BCD display output.
// Optional COUNTDOWN_AUTO_RELOAD_EN: reload the preset on expiry instead of stopping.
module countdown_timer_core #(
  parameter int unsigned HOUR_MAX = 23
) (
  input  logic              clk_1hz,
  input  logic              rst,
  countdown_timer_if.slave  bus
);

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] RUN     = 2'b01;
  localparam logic [1:0] PAUSE   = 2'b10;
  localparam logic [1:0] EXPIRED = 2'b11;

  logic [1:0] state_q, state_d;
  logic [4:0] h_q, h_d;
  logic [5:0] m_q, m_d;
  logic [5:0] s_q, s_d;
  logic       pulse_q, pulse_d;

  logic [4:0] pre_h;
  logic [5:0] pre_m, pre_s;
  logic       count_zero, count_one, preset_zero;

  assign pre_h = (bus.preset_h > 5'(HOUR_MAX)) ? 5'(HOUR_MAX) : bus.preset_h;
  assign pre_m = (bus.preset_m > 6'd59) ? 6'd59 : bus.preset_m;
  assign pre_s = (bus.preset_s > 6'd59) ? 6'd59 : bus.preset_s;

  assign count_zero  = (h_q == '0) && (m_q == '0) && (s_q == '0);
  assign count_one   = (h_q == '0) && (m_q == '0) && (s_q == 6'd1);
  assign preset_zero = (pre_h == '0) && (pre_m == '0) && (pre_s == '0);

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    m_d     = m_q;
    s_d     = s_q;
    pulse_d = 1'b0;
    if (bus.load) begin
      h_d     = pre_h;
      m_d     = pre_m;
      s_d     = pre_s;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start && !count_zero) state_d = RUN;
        end
        RUN: begin
          if (bus.pause) begin
            state_d = PAUSE;
          end else if (count_zero) begin
            state_d = EXPIRED;
          end else begin
            if (s_q != '0) begin
              s_d = s_q - 6'd1;
            end else if (m_q != '0) begin
              s_d = 6'd59;
              m_d = m_q - 6'd1;
            end else begin
              s_d = 6'd59;
              m_d = 6'd59;
              h_d = h_q - 5'd1;
            end
            if (count_one) begin
              pulse_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              // A zero preset cannot be reloaded meaningfully, so it falls back to one-shot expiry.
              if (!preset_zero) begin
                h_d = pre_h;
                m_d = pre_m;
                s_d = pre_s;
              end else begin
                state_d = EXPIRED;
              end
`else
              state_d = EXPIRED;
`endif
            end
          end
        end
        PAUSE: begin
          if (bus.start) state_d = RUN;
        end
        EXPIRED: begin
          state_d = EXPIRED;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_1hz or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      h_q     <= '0;
      m_q     <= '0;
      s_q     <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      m_q     <= m_d;
      s_q     <= s_d;
      pulse_q <= pulse_d;
    end
  end

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    return (8'(v / 6'd10) << 4) | 8'(v % 6'd10);
  endfunction

  assign bus.time_data    = {8'h00, to_bcd({1'b0, h_q}), to_bcd(m_q), to_bcd(s_q)};
  assign bus.state        = state_q;
  assign bus.running      = (state_q == RUN);
  assign bus.expired      = (state_q == EXPIRED);
  assign bus.expire_pulse = pulse_q;

  // preset_zero only feeds the reload path; keep it referenced in the one-shot build.
`ifndef COUNTDOWN_AUTO_RELOAD_EN
  logic unused_preset_zero;
  assign unused_preset_zero = preset_zero;
`endif

endmodule

// File: tb/tb_countdown_timer_core.sv
// Self-checking bench for countdown_timer_core: directed scenarios plus random stimulus vs a seconds-count model.
module tb_countdown_timer_core;

  localparam int HM = 23;

  logic clk_1hz = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  int m_state;
  int m_cnt;
  bit m_pulse;

  countdown_timer_if bus();

  countdown_timer_core #(.HOUR_MAX(HM)) dut (
    .clk_1hz(clk_1hz),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_1hz = ~clk_1hz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp_secs(input int h, input int m, input int s);
    int hh, mm, ss;
    hh = (h > HM) ? HM : h;
    mm = (m > 59) ? 59 : m;
    ss = (s > 59) ? 59 : s;
    return hh * 3600 + mm * 60 + ss;
  endfunction

  function automatic logic [31:0] exp_td(input int c);
    int h, m, s;
    h = c / 3600;
    m = (c / 60) % 60;
    s = c % 60;
    return {8'h00, 4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".time_data"}, bus.time_data, exp_td(m_cnt));
    check({tag, ".state"}, {30'd0, bus.state}, 32'(m_state));
    check({tag, ".flags"}, {29'd0, bus.running, bus.expired, bus.expire_pulse},
          {29'd0, m_state == 1, m_state == 3, m_pulse});
  endtask

  // One clock edge: drive inputs, advance the model, sample 1 time unit after the edge.
  task automatic cycle(input bit ld, input bit st, input bit ps,
                       input int ph, input int pm, input int psx, input string tag);
    int pre;
    bus.load     = ld;
    bus.start    = st;
    bus.pause    = ps;
    bus.preset_h = 5'(ph);
    bus.preset_m = 6'(pm);
    bus.preset_s = 6'(psx);
    @(posedge clk_1hz);
    pre     = clamp_secs(ph, pm, psx);
    m_pulse = 1'b0;
    if (ld) begin
      m_cnt   = pre;
      m_state = 0;
    end else begin
      case (m_state)
        0: if (st && m_cnt != 0) m_state = 1;
        1: begin
          if (ps) begin
            m_state = 2;
          end else begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
              m_pulse = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              if (pre != 0) m_cnt = pre;
              else m_state = 3;
`else
              m_state = 3;
`endif
            end
          end
        end
        2: if (st) m_state = 1;
        default: ;
      endcase
    end
    #1;
    check_all(tag);
  endtask

  task automatic reset_model();
    m_state = 0;
    m_cnt   = 0;
    m_pulse = 1'b0;
  endtask

  initial begin
    int ph, pm, psx;
    bit ld, st, ps;

    rst          = 1'b0;
    bus.load     = 1'b0;
    bus.start    = 1'b0;
    bus.pause    = 1'b0;
    bus.preset_h = '0;
    bus.preset_m = '0;
    bus.preset_s = '0;
    reset_model();
    #12;
    check_all("reset");
    rst = 1'b1;

    // Load 0:0:3 and count down to expiry.
    cycle(1, 0, 0, 0, 0, 3, "ld3");
    check("ld3.td", bus.time_data, 32'h00000003);
    cycle(0, 1, 0, 0, 0, 3, "st3");
    cycle(0, 0, 0, 0, 0, 3, "run2");
    check("run2.td", bus.time_data, 32'h00000002);
    cycle(0, 0, 0, 0, 0, 3, "run1");
    cycle(0, 0, 0, 0, 0, 3, "run0");
    check("run0.pulse", {31'd0, bus.expire_pulse}, 32'd1);
`ifndef COUNTDOWN_AUTO_RELOAD_EN
    check("run0.td", bus.time_data, 32'h00000000);
    cycle(0, 1, 1, 0, 0, 3, "exp_hold");
    check("exp_hold.exp", {30'd0, bus.expired, bus.expire_pulse}, 32'd2);
`endif

    // Borrow across minutes and hours.
    cycle(1, 0, 0, 1, 0, 0, "ld1h");
    cycle(0, 1, 0, 1, 0, 0, "st1h");
    cycle(0, 0, 0, 1, 0, 0, "wrap1h");
    check("wrap1h.td", bus.time_data, 32'h00005959);
    cycle(1, 0, 0, 10, 0, 0, "ld10h");
    check("ld10h.td", bus.time_data, 32'h00100000);
    cycle(0, 1, 0, 10, 0, 0, "st10h");
    cycle(0, 0, 0, 10, 0, 0, "wrap10h");
    check("wrap10h.td", bus.time_data, 32'h00095959);

    // Clamping of out-of-range presets.
    cycle(1, 0, 0, 31, 63, 60, "clamp");
    check("clamp.td", bus.time_data, 32'h00235959);

    // Pause holds, start resumes one edge later, load beats start.
    cycle(1, 0, 0, 0, 0, 10, "ld10");
    cycle(0, 1, 0, 0, 0, 10, "st10");
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 1, 0, 0, 10, "pause");
      check("pause.td", bus.time_data, 32'h00000010);
    end
    cycle(0, 1, 0, 0, 0, 10, "resume");
    cycle(0, 0, 0, 0, 0, 10, "resume_dec");
    check("resume_dec.td", bus.time_data, 32'h00000009);
    cycle(1, 1, 0, 0, 5, 7, "ld_st");
    check("ld_st.state", {30'd0, bus.state}, 32'd0);
    cycle(0, 1, 0, 0, 0, 0, "st_nz");

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    cycle(1, 0, 0, 0, 0, 2, "ar_ld");
    cycle(0, 1, 0, 0, 0, 2, "ar_st");
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 0, 0, 2, "ar_run");
      check("ar_run.state", {30'd0, bus.state}, 32'd1);
    end
`endif

    // Asynchronous reset in the middle of a run at 00:00:37.
    cycle(1, 0, 0, 0, 0, 40, "ld40");
    cycle(0, 1, 0, 0, 0, 40, "st40");
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 40, "run40");
    check("pre_rst.td", bus.time_data, 32'h00000037);
    #2 rst = 1'b0;
    reset_model();
    #1;
    check_all("async_rst");
    @(posedge clk_1hz);
    #1;
    check_all("rst_hold");
    rst = 1'b1;

    // Random traffic, biased toward short presets so expiries happen.
    for (int i = 0; i < 600; i++) begin
      ld = ($urandom_range(0, 99) < 8);
      st = ($urandom_range(0, 99) < 30);
      ps = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 1) == 1) begin
        ph  = 0;
        pm  = 0;
        psx = $urandom_range(0, 9);
      end else begin
        ph  = $urandom_range(0, 31);
        pm  = $urandom_range(0, 63);
        psx = $urandom_range(0, 63);
      end
      cycle(ld, st, ps, ph, pm, psx, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer_core.md
# countdown_timer_core

Countdown timer stage clocked by the 1 Hz tick. It holds an hours/minutes/seconds count loaded from switch presets and decrements it once per `clk_1hz` edge while running. It publishes the count as a packed BCD word for the eight-digit display driver downstream. Expiry is flagged both as a level and as a one-tick pulse.

## Interface
- `HOUR_MAX`, default 23: largest loadable hours value; presets above it clamp to it.
- `clk_1hz`  in  1  1 Hz tick clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `load`  in  1  level; when sampled high, copies the preset into the count.
- `start`  in  1  level; starts or resumes counting.
- `pause`  in  1  level; freezes counting.
- `preset_h`  in  5  preset hours, binary.
- `preset_m`  in  6  preset minutes, binary; values above 59 clamp to 59.
- `preset_s`  in  6  preset seconds, binary; values above 59 clamp to 59.
- `time_data`  out  32  packed BCD: [31:24]=0, [23:20] hours tens, [19:16] hours ones, [15:12] min tens, [11:8] min ones, [7:4] sec tens, [3:0] sec ones.
- `state`  out  2  IDLE=00, RUN=01, PAUSE=10, EXPIRED=11.
- `running`  out  1  high when `state`==RUN.
- `expired`  out  1  high when `state`==EXPIRED.
- `expire_pulse`  out  1  high for exactly one `clk_1hz` cycle when the count reaches 0.

## Operation
- Count registers `h`, `m`, `s` are binary. `time_data` is combinational BCD of those registers; every nibble is in the range 0–9.
- Inputs are sampled on each `clk_1hz` rising edge. Priority: load > start > pause.
- IDLE: on `load`, count = clamped preset and the state stays IDLE. On `start` with count != 0, go to RUN. On `start` with count == 0, stay in IDLE.
- RUN: on `load`, count = preset and go to IDLE with no decrement. On `pause`, go to PAUSE with no decrement that edge. Otherwise decrement by one second:
  - s>0: s-1.
  - s==0, m>0: s=59, m-1.
  - s==0, m==0: s=59, m=59, h-1.
- RUN reaching zero: when the count is 00:00:01, the decrement yields 00:00:00. On that edge `expire_pulse`=1 and the next state is EXPIRED.
- PAUSE: on `load`, load the preset and go to IDLE. On `start`, go to RUN; the decrement resumes on the following edge. `pause` held in PAUSE has no effect.
- EXPIRED: the count holds 00:00:00 and `start`/`pause` are ignored. On `load`, load the preset and go to IDLE.
- `expire_pulse` is registered and deasserts on the next edge unconditionally.

## Timing
- Reset (async, `rst`=0): `state`=IDLE, count=00:00:00, `time_data`=32'h0, `running`=0, `expired`=0, `expire_pulse`=0. Reset takes effect immediately mid-count and also clears a pending pulse.
- Latency:
  - `load` edge: `time_data` shows the preset after the same edge, with zero added cycles.
  - `start` edge: the state becomes RUN at that edge. The first decrement happens on the next edge.
- From a loaded count of N seconds plus `start` at edge 0, `expire_pulse` rises after edge N and `expired` rises at the same edge.
- Simultaneous `load`+`start` in IDLE: load wins and the state stays IDLE.
- Simultaneous `pause`+`start` in RUN: start is a no-op and pause wins.
- Wrap-around 01:00:00 -> 00:59:59 in a single edge.

## Configuration
- `COUNTDOWN_AUTO_RELOAD_EN` defined:
  - On reaching zero in RUN, `expire_pulse` fires and the count reloads the current clamped preset on the same edge. The state stays RUN and EXPIRED is never entered from RUN.
  - If the preset is 00:00:00, go to EXPIRED as in the undefined case.
- Undefined: the block behaves exactly as in Operation (one-shot).

## Test plan
- Reset mid-run at count 00:00:37 -> the next sampled values are `time_data`=32'h0, `state`=00, and all flags are 0.
- `preset`=0:0:3, `load`, then `start` -> `time_data` reads 00000003, 00000002, 00000001, 00000000 on consecutive edges. `expire_pulse` is high for one cycle at the last edge, and `expired` stays 1 after it.
- Borrow: load 1:00:00 and run one edge -> `time_data`=32'h00005959 with hours 00. Load 10:00:00 -> 32'h00100000; one edge later -> 32'h00095959.
- Clamp: `preset_h`=31, `preset_m`=63, `preset_s`=60 with `load` -> `time_data`=32'h00235959.
- Pause/priority:
  - Running at 00:00:10, pause for 3 edges -> the count stays 00:00:10.
  - `start` -> the next edge gives 00:00:09.
  - `load`+`start` together -> IDLE with the preset loaded.
- With `COUNTDOWN_AUTO_RELOAD_EN` and preset 0:0:2 -> the count sequence is 2,1,2,1,…; `expire_pulse` fires every 2nd edge and the state stays 01.
